// File: rtl/dig_pkg.sv
// Shared constants for the 8-digit 7-segment scan controller: register map,
// reset values and the hex-to-segment table.
package dig_pkg;

    localparam int DIG_COUNT = 8;

    localparam logic [11:0] DIG_DATA_OFS = 12'h000;
    localparam logic [11:0] DIG_CTRL_OFS = 12'h004;

    localparam logic [31:0] DIG_DATA_RST = 32'h0000_0000;
    localparam logic [31:0] DIG_CTRL_RST = 32'h0000_00FF;

    // Element n is the active-high {G,F,E,D,C,B,A} pattern for hex digit n.
    localparam logic [15:0][6:0] HEX7_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/dig_scan_ctrl_seg7_decode.sv
// Combinational nibble to 7-segment decoder (bit0 = A ... bit6 = G).
module seg7_decode
    import dig_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_pat
);

    assign seg_pat = HEX7_TABLE[nibble];

endmodule

// File: rtl/dig_scan_ctrl.sv
// Memory-mapped 8-digit 7-segment scan controller with DATA/CTRL registers.
// Optional leading-zero suppression is built when DIG_BLANK_EN is defined.
module dig_scan_ctrl
    import dig_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] addr,
    input  logic [3:0]  we,
    input  logic [31:0] wdata,
    output logic [7:0]  dig_en,
    output logic [7:0]  seg
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] div_cnt;
    logic [2:0]       idx;
    logic [31:0]      data_q;
    logic [7:0]       mask_q;
    logic [7:0]       dp_q;

    logic             data_sel;
    logic             ctrl_sel;
    logic [3:0]       nibble;
    logic [6:0]       seg_pat;
    logic             blank_sel;
    logic             unused_addr_lsb;

    assign data_sel        = (addr[11:2] == DIG_DATA_OFS[11:2]);
    assign ctrl_sel        = (addr[11:2] == DIG_CTRL_OFS[11:2]);
    assign unused_addr_lsb = ^addr[1:0];
    assign nibble          = data_q[{idx, 2'b00} +: 4];

    seg7_decode u_seg7_decode (
        .nibble  (nibble),
        .seg_pat (seg_pat)
    );

`ifdef DIG_BLANK_EN
    // lead_zero[i]: nibbles 7..i are all zero.
    logic [DIG_COUNT-1:0] lead_zero;

    always_comb begin
        lead_zero    = '0;
        lead_zero[7] = (data_q[31:28] == 4'h0);
        for (int i = DIG_COUNT - 2; i >= 0; i--) begin
            lead_zero[i] = lead_zero[i+1] && (data_q[4*i +: 4] == 4'h0);
        end
        blank_sel = (idx != 3'd0) && lead_zero[idx] && !dp_q[idx];
    end
`else
    assign blank_sel = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= 3'd0;
            data_q  <= DIG_DATA_RST;
            mask_q  <= DIG_CTRL_RST[7:0];
            dp_q    <= DIG_CTRL_RST[15:8];
            dig_en  <= 8'h00;
            seg     <= 8'h00;
        end else begin
            if (div_cnt == CNT_LAST) begin
                div_cnt <= '0;
                idx     <= idx + 3'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            for (int n = 0; n < 4; n++) begin
                if (data_sel && we[n]) begin
                    data_q[8*n +: 8] <= wdata[8*n +: 8];
                end
            end
            // CTRL upper half is reserved; those lanes are simply not stored.
            if (ctrl_sel && we[0]) mask_q <= wdata[7:0];
            if (ctrl_sel && we[1]) dp_q   <= wdata[15:8];

            dig_en <= (mask_q[idx] && !blank_sel) ? (8'h01 << idx) : 8'h00;
            seg    <= {dp_q[idx], seg_pat};
        end
    end

endmodule

// File: doc/dig_scan_ctrl.md
Name: dig_scan_ctrl

Overview:
Memory-mapped controller for the board's eight-digit 7-segment display, attached to the Bridge digit port (rst_to_dig/clk_to_dig/addr_to_dig/we_to_dig/wdata_to_dig).
- Holds a 32-bit hex data register and a control register, both written by CPU stores.
- Time-multiplexes the digits: a prescaler counter advances a digit index.
- Drives the one-hot digit enable and the segment pattern of the selected nibble.
- Write-only; the Bridge returns 0 on reads of this range.

Parameters:
SCAN_DIV, 50000, cpu_clk cycles each digit stays lit (legal range ≥2); counter width = $clog2(SCAN_DIV).

Ports:
clk  in  1  clock (Bridge clk_to_dig = cpu_clk)
rst  in  1  reset
addr  in  12  byte offset within the display window
we  in  4  byte write enables, bit n → wdata[8n+7:8n]
wdata  in  32  store data
dig_en  out  8  one-hot digit enable, active-high, bit i = digit i (rightmost = 0)
seg  out  8  segment pattern, active-high; bit0=A … bit6=G, bit7=DP

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state updates on the rising clk edge.
- Register map (decoded on addr[11:2]; other offsets ignored; addr[1:0] ignored):
  - 0x000 DATA: digit i shows bits[4i+3:4i]. Reset value 0x0000_0000.
  - 0x004 CTRL: [7:0] digit mask, reset 0xFF; [15:8] DP mask, reset 0x00; [31:16] reserved, reads as 0, writes dropped.
- Writes: each byte lane with we[n]=1 is updated at the edge. Lanes with we[n]=0 are unchanged. we=0 is a no-op.
- Prescaler div_cnt counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it returns to 0 and idx (3 bits) increments.
  - idx wraps from 7 to 0.
- Outputs are registered every cycle:
  - dig_en ← (mask[idx] && !blank(idx)) ? 1<<idx : 0.
  - seg ← {dp[idx], hex7(DATA nibble idx)}.
  - hex7 values: 0x3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F, 77, 7C, 39, 5E, 79, 71 for 0–F.
- Latency:
  - A register write is visible on seg/dig_en at the edge after the write edge, provided idx selects that digit.
  - A write coinciding with an idx advance takes effect on the next output update with the new idx.
- Reset (asserted at any time, including mid-scan):
  - Next edge: div_cnt=0, idx=0, DATA=0, CTRL=0x0000_00FF, dig_en=0x00, seg=0x00.
  - A write in the same cycle as rst is discarded.
  - First cycle after rst deasserts: dig_en=0x01, seg=0x3F.
- No handshake or backpressure: a write is always accepted in one cycle.

Optional Feature:
DIG_BLANK_EN, leading-zero suppression.
- Defined: blank(i)=1 when i≠0, nibbles 7..i are all zero, and dp[i]=0. Digit 0 is never blanked.
- Undefined: blank(i)=0 and all masked-on digits are lit.

Decomposition:
- Package dig_pkg:
  - register offsets DIG_DATA_OFS=0x000, DIG_CTRL_OFS=0x004;
  - reset constants DIG_DATA_RST, DIG_CTRL_RST;
  - the 16-entry hex7 segment table;
  - digit count 8.
- One sub-module, seg7_decode: combinational 4-bit nibble → 7-bit segment pattern using the table.
- Scan, register and blanking logic stay in dig_scan_ctrl.

Test Plan:
1. SCAN_DIV=4, pulse rst for 2 cycles → during reset dig_en=0x00, seg=0x00. Cycle 1 after release: dig_en=0x01, seg=0x3F. dig_en=0x02 four cycles later, 0x80 at cycle 29, back to 0x01 at cycle 33.
2. Write DATA=0x1234ABCD, we=0xF → digit0 seg=0x5E, digit1 0x39, digit2 0x7C, digit3 0x77, digit7 0x06.
3. From DATA=0x1234ABCD, write we=0x2, wdata=0x0000_9900 → DATA=0x123499CD. Digit2 and digit3 both show 0x6F; other digits unchanged. Same data with we=0x0 → no change.
4. Write CTRL=0x0000_010F → dig_en=0x00 while idx=4..7; digit0 seg=0xDE (0x5E|DP). Write to offset 0x008 → no state change.
5. Assert rst while idx=5 and a DATA write is on the bus → next edge: all reset values, write discarded. First cycle after release: dig_en=0x01, seg=0x3F.
6. DATA=0x0000_0012:
   - with DIG_BLANK_EN: digits 2..7 dig_en=0, digit1 0x06, digit0 0x5B.
   - without DIG_BLANK_EN: digits 2..7 show 0x3F.
   - DATA=0 with DIG_BLANK_EN: only digit0 lit, showing 0x3F.
